// File: rtl/tank_command_sequencer_pkg.sv
// Shared encodings for the tank command sequencer: storage register selects,
// direction codes, command encoding and sequencer FSM states.
package game_pkg;

  localparam logic [3:0] MODE_NONE    = 4'b0000;
  localparam logic [3:0] MODE_T1_POS  = 4'b0001;
  localparam logic [3:0] MODE_T1_DIR  = 4'b0010;
  localparam logic [3:0] MODE_T1_PROJ = 4'b0011;
  localparam logic [3:0] MODE_T2_POS  = 4'b0100;
  localparam logic [3:0] MODE_T2_DIR  = 4'b0101;
  localparam logic [3:0] MODE_T2_PROJ = 4'b0110;

  localparam logic [7:0] DIR_UP    = 8'b0000_0000;
  localparam logic [7:0] DIR_DOWN  = 8'b0000_0001;
  localparam logic [7:0] DIR_LEFT  = 8'b0000_0011;
  localparam logic [7:0] DIR_RIGHT = 8'b0000_0111;

  typedef enum logic [2:0] {
    CMD_FIRE  = 3'd0,
    CMD_UP    = 3'd1,
    CMD_DOWN  = 3'd2,
    CMD_LEFT  = 3'd3,
    CMD_RIGHT = 3'd4
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_SELF  = 3'd1,
    ST_RD_OTHER = 3'd2,
    ST_CHECK    = 3'd3,
    ST_WR_DIR   = 3'd4,
    ST_WR_POS   = 3'd5,
    ST_WR_PROJ  = 3'd6,
    ST_DONE     = 3'd7
  } state_e;

  // Request bits are {fire, up, down, left, right}; leftmost set bit wins.
  function automatic cmd_e cmd_from_req(input logic [4:0] req);
    if (req[4]) return CMD_FIRE;
    if (req[3]) return CMD_UP;
    if (req[2]) return CMD_DOWN;
    if (req[1]) return CMD_LEFT;
    return CMD_RIGHT;
  endfunction

  function automatic logic [7:0] dir_code(input cmd_e cmd);
    case (cmd)
      CMD_UP:   return DIR_UP;
      CMD_DOWN: return DIR_DOWN;
      CMD_LEFT: return DIR_LEFT;
      default:  return DIR_RIGHT;
    endcase
  endfunction

  function automatic logic [3:0] pos_mode(input logic player);
    return player ? MODE_T2_POS : MODE_T1_POS;
  endfunction

  function automatic logic [3:0] dir_mode(input logic player);
    return player ? MODE_T2_DIR : MODE_T1_DIR;
  endfunction

  function automatic logic [3:0] proj_mode(input logic player);
    return player ? MODE_T2_PROJ : MODE_T1_PROJ;
  endfunction

endpackage

// File: rtl/tank_command_sequencer_grid_step.sv
// One-step move evaluator: target position for a command plus whether the
// move stays on the grid and avoids the other tank.
module grid_step
  import game_pkg::*;
#(
  parameter int GRID_COLS = 8,
  parameter int GRID_ROWS = 8
) (
  input  logic [7:0] self_pos,
  input  logic [7:0] other_pos,
  input  logic [2:0] cmd,
  output logic [7:0] target,
  output logic       legal
);

  localparam logic [3:0] COL_LAST = 4'(GRID_COLS - 1);
  localparam logic [3:0] ROW_LAST = 4'(GRID_ROWS - 1);

  logic [3:0] col;
  logic [3:0] row;
  logic       in_bounds;

  assign col = self_pos[7:4];
  assign row = self_pos[3:0];

  always_comb begin
    target    = self_pos;
    in_bounds = 1'b0;
    case (cmd)
      CMD_UP: begin
        target    = {col, row - 4'd1};
        in_bounds = (row != 4'd0);
      end
      CMD_DOWN: begin
        target    = {col, row + 4'd1};
        in_bounds = (row < ROW_LAST);
      end
      CMD_LEFT: begin
        target    = {col - 4'd1, row};
        in_bounds = (col != 4'd0);
      end
      CMD_RIGHT: begin
        target    = {col + 4'd1, row};
        in_bounds = (col < COL_LAST);
      end
      default: begin
        target    = self_pos;
        in_bounds = 1'b0;
      end
    endcase
  end

  assign legal = in_bounds && (target != other_pos);

endmodule

// File: rtl/tank_command_sequencer.sv
// Arbitrates two players' move/fire requests and turns each accepted request
// into one read-modify-write transaction on the storage register port.
module tank_command_sequencer
  import game_pkg::*;
#(
  parameter int GRID_COLS = 8,
  parameter int GRID_ROWS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       p1_up,
  input  logic       p1_down,
  input  logic       p1_left,
  input  logic       p1_right,
  input  logic       p1_fire,
  input  logic       p2_up,
  input  logic       p2_down,
  input  logic       p2_left,
  input  logic       p2_right,
  input  logic       p2_fire,
  input  logic [7:0] q,
  output logic [3:0] mode,
  output logic       wren,
  output logic [7:0] address,
  output logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       p1_shot,
  output logic       p2_shot
);

  logic [4:0] req        [2];
  logic       slot_valid [2];
  cmd_e       slot_cmd   [2];

  state_e     state_q;
  logic       ptr_q;
  logic       cur_q;
  cmd_e       cur_cmd_q;
  logic [7:0] self_pos_q;
  logic [7:0] target_q;
  logic       legal_q;
  logic [3:0] mode_q;
  logic       wren_q;
  logic [7:0] addr_q;
  logic [7:0] data_q;
  logic       busy_q;
  logic       done_q;
  logic       p1_shot_q;
  logic       p2_shot_q;

  logic       sel_d;
  logic [7:0] step_target;
  logic       step_legal;

  assign req[0] = {p1_fire, p1_up, p1_down, p1_left, p1_right};
  assign req[1] = {p2_fire, p2_up, p2_down, p2_left, p2_right};

  // One pending slot per player; pulses are dropped while the slot is full.
  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    logic valid_q;
    cmd_e cmd_q;
    logic clear;

    assign clear = (state_q == ST_DONE) && (cur_q == 1'(gi));

    always_ff @(posedge clk) begin
      if (!reset) begin
        valid_q <= 1'b0;
        cmd_q   <= CMD_FIRE;
      end else if (valid_q) begin
        if (clear) valid_q <= 1'b0;
      end else if (|req[gi]) begin
        valid_q <= 1'b1;
        cmd_q   <= cmd_from_req(req[gi]);
      end
    end

    assign slot_valid[gi] = valid_q;
    assign slot_cmd[gi]   = cmd_q;
  end

  always_comb begin
    sel_d = ptr_q;
    if (ptr_q == 1'b0) sel_d = slot_valid[0] ? 1'b0 : 1'b1;
    else               sel_d = slot_valid[1] ? 1'b1 : 1'b0;
  end

  // During CHECK the storage read data is the other tank's position.
  grid_step #(
    .GRID_COLS(GRID_COLS),
    .GRID_ROWS(GRID_ROWS)
  ) u_grid_step (
    .self_pos (self_pos_q),
    .other_pos(q),
    .cmd      (cur_cmd_q),
    .target   (step_target),
    .legal    (step_legal)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= 1'b0;
      cur_q      <= 1'b0;
      cur_cmd_q  <= CMD_FIRE;
      self_pos_q <= 8'h00;
      target_q   <= 8'h00;
      legal_q    <= 1'b0;
      mode_q     <= MODE_NONE;
      wren_q     <= 1'b0;
      addr_q     <= 8'h00;
      data_q     <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      p1_shot_q  <= 1'b0;
      p2_shot_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (slot_valid[0] || slot_valid[1]) begin
            cur_q     <= sel_d;
            cur_cmd_q <= slot_cmd[sel_d];
            mode_q    <= pos_mode(sel_d);
            busy_q    <= 1'b1;
            state_q   <= ST_RD_SELF;
          end
        end
        ST_RD_SELF: begin
          mode_q  <= pos_mode(~cur_q);
          state_q <= ST_RD_OTHER;
        end
        ST_RD_OTHER: begin
          self_pos_q <= q;
          state_q    <= ST_CHECK;
        end
        ST_CHECK: begin
          target_q <= step_target;
          legal_q  <= step_legal;
          wren_q   <= 1'b1;
          if (cur_cmd_q == CMD_FIRE) begin
            mode_q  <= proj_mode(cur_q);
            data_q  <= self_pos_q;
            addr_q  <= self_pos_q;
            if (cur_q) p2_shot_q <= 1'b1;
            else       p1_shot_q <= 1'b1;
            state_q <= ST_WR_PROJ;
          end else begin
            mode_q  <= dir_mode(cur_q);
            data_q  <= dir_code(cur_cmd_q);
            addr_q  <= dir_code(cur_cmd_q);
            state_q <= ST_WR_DIR;
          end
        end
        ST_WR_DIR: begin
          // The direction always lands; the position only if the step is legal.
          if (legal_q) begin
            mode_q  <= pos_mode(cur_q);
            data_q  <= target_q;
            addr_q  <= target_q;
            state_q <= ST_WR_POS;
          end else begin
            mode_q  <= MODE_NONE;
            wren_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_WR_POS, ST_WR_PROJ: begin
          mode_q    <= MODE_NONE;
          wren_q    <= 1'b0;
          p1_shot_q <= 1'b0;
          p2_shot_q <= 1'b0;
          done_q    <= 1'b1;
          state_q   <= ST_DONE;
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ptr_q   <= ~ptr_q;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mode    = mode_q;
  assign wren    = wren_q;
  assign address = addr_q;
  assign data    = data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign p1_shot = p1_shot_q;
  assign p2_shot = p2_shot_q;

endmodule

// File: tb/tb_tank_command_sequencer.sv
// Directed bench: a registered-read storage model sits behind the sequencer
// and each scenario task checks writes, timing and resulting register contents.
module tb_tank_command_sequencer;
  import game_pkg::*;

  localparam logic [4:0] R_NONE  = 5'b00000;
  localparam logic [4:0] R_FIRE  = 5'b10000;
  localparam logic [4:0] R_UP    = 5'b01000;
  localparam logic [4:0] R_DOWN  = 5'b00100;
  localparam logic [4:0] R_LEFT  = 5'b00010;
  localparam logic [4:0] R_RIGHT = 5'b00001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b0;
  logic       p1_up = 0, p1_down = 0, p1_left = 0, p1_right = 0, p1_fire = 0;
  logic       p2_up = 0, p2_down = 0, p2_left = 0, p2_right = 0, p2_fire = 0;
  logic [7:0] q;
  logic [3:0] mode;
  logic       wren;
  logic [7:0] address;
  logic [7:0] data;
  logic       busy;
  logic       done;
  logic       p1_shot;
  logic       p2_shot;

  tank_command_sequencer #(.GRID_COLS(8), .GRID_ROWS(8)) dut (
    .clk(clk), .reset(reset),
    .p1_up(p1_up), .p1_down(p1_down), .p1_left(p1_left), .p1_right(p1_right), .p1_fire(p1_fire),
    .p2_up(p2_up), .p2_down(p2_down), .p2_left(p2_left), .p2_right(p2_right), .p2_fire(p2_fire),
    .q(q), .mode(mode), .wren(wren), .address(address), .data(data),
    .busy(busy), .done(done), .p1_shot(p1_shot), .p2_shot(p2_shot)
  );

  // Storage model: registered read, write on wren, plus a bench preload port.
  logic [7:0] regs [16];
  logic       pl_en = 1'b0;
  logic [3:0] pl_mode = 4'h0;
  logic [7:0] pl_val = 8'h00;

  always @(posedge clk) begin
    if (pl_en) regs[pl_mode] <= pl_val;
    else if (wren) regs[mode] <= data;
    q <= regs[mode];
  end

  typedef struct {
    int         cyc;
    logic [3:0] m;
    logic [7:0] d;
    logic [7:0] a;
    logic       s1;
    logic       s2;
  } wr_t;

  wr_t wq[$];
  int  txn_cycles;
  bit  txn_ok;
  int  shot1_cnt, shot2_cnt;
  int  total = 0;
  int  bad = 0;

  task automatic preload(input logic [3:0] m, input logic [7:0] v);
    @(negedge clk);
    pl_en = 1'b1; pl_mode = m; pl_val = v;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic send(input logic [4:0] r1, input logic [4:0] r2);
    @(negedge clk);
    {p1_fire, p1_up, p1_down, p1_left, p1_right} = r1;
    {p2_fire, p2_up, p2_down, p2_left, p2_right} = r2;
    @(negedge clk);
    {p1_fire, p1_up, p1_down, p1_left, p1_right} = 5'b0;
    {p2_fire, p2_up, p2_down, p2_left, p2_right} = 5'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    @(negedge clk); reset = 1'b1;
  endtask

  // Follows one transaction to its done pulse; p2_noise is pulsed on the
  // second and fourth cycles to exercise request dropping.
  task automatic wait_done(input string tag, input logic [4:0] p2_noise);
    wq.delete();
    txn_cycles = 0; txn_ok = 0; shot1_cnt = 0; shot2_cnt = 0;
    for (int i = 0; i < 30 && !txn_ok; i++) begin
      @(negedge clk);
      {p2_fire, p2_up, p2_down, p2_left, p2_right} = (i == 1 || i == 3) ? p2_noise : 5'b0;
      if (busy) txn_cycles++;
      if (p1_shot) shot1_cnt++;
      if (p2_shot) shot2_cnt++;
      if (wren) wq.push_back('{txn_cycles, mode, data, address, p1_shot, p2_shot});
      if (done) txn_ok = 1;
    end
    {p2_fire, p2_up, p2_down, p2_left, p2_right} = 5'b0;
    total++;
    if (!txn_ok) begin bad++; $display("FAIL %s_timeout: done not seen within 30 cycles", tag); end
    $display("txn %s: busy_cycles=%0d writes=%0d shots=%0d/%0d", tag, txn_cycles, wq.size(), shot1_cnt, shot2_cnt);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (mode !== 4'h0)  begin bad++; $display("FAIL rst_mode: got %h expected 0", mode); end
    total++; if (wren !== 1'b0)  begin bad++; $display("FAIL rst_wren: got %b expected 0", wren); end
    total++; if (address !== 8'h00) begin bad++; $display("FAIL rst_address: got %h expected 00", address); end
    total++; if (data !== 8'h00) begin bad++; $display("FAIL rst_data: got %h expected 00", data); end
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL rst_busy: got %b expected 0", busy); end
    total++; if (done !== 1'b0)  begin bad++; $display("FAIL rst_done: got %b expected 0", done); end
    total++; if ({p1_shot, p2_shot} !== 2'b00) begin bad++; $display("FAIL rst_shot: got %b expected 00", {p1_shot, p2_shot}); end
    reset = 1'b1;
  endtask

  task automatic test_legal_move();
    preload(MODE_T1_POS, 8'h21);
    preload(MODE_T2_POS, 8'h66);
    send(R_UP, R_NONE);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL legal_latch_idle: busy got %b expected 0", busy); end
    wait_done("legal_up", R_NONE);
    total++; if (txn_cycles != 6) begin bad++; $display("FAIL legal_cycles: got %0d expected 6", txn_cycles); end
    total++; if (wq.size() != 2) begin bad++; $display("FAIL legal_nwrites: got %0d expected 2", wq.size()); end
    if (wq.size() == 2) begin
      total++; if (wq[0].cyc != 4 || wq[0].m !== 4'h2 || wq[0].d !== 8'h00)
        begin bad++; $display("FAIL legal_wr_dir: got cyc=%0d mode=%h data=%h expected cyc=4 mode=2 data=00", wq[0].cyc, wq[0].m, wq[0].d); end
      total++; if (wq[1].cyc != 5 || wq[1].m !== 4'h1 || wq[1].d !== 8'h20 || wq[1].a !== 8'h20)
        begin bad++; $display("FAIL legal_wr_pos: got cyc=%0d mode=%h data=%h addr=%h expected cyc=5 mode=1 data=20 addr=20", wq[1].cyc, wq[1].m, wq[1].d, wq[1].a); end
    end
    total++; if (regs[1] !== 8'h20) begin bad++; $display("FAIL legal_t1_pos: got %h expected 20", regs[1]); end
    @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL legal_after: busy=%b done=%b expected 0 0", busy, done); end
  endtask

  task automatic test_blocked_edge();
    preload(MODE_T1_DIR, 8'hAA);
    preload(MODE_T1_POS, 8'h20);
    send(R_UP, R_NONE);
    wait_done("blocked_row0", R_NONE);
    total++; if (txn_cycles != 5) begin bad++; $display("FAIL row0_cycles: got %0d expected 5", txn_cycles); end
    total++; if (wq.size() != 1) begin bad++; $display("FAIL row0_nwrites: got %0d expected 1", wq.size()); end
    if (wq.size() == 1) begin
      total++; if (wq[0].cyc != 4 || wq[0].m !== 4'h2 || wq[0].d !== 8'h00)
        begin bad++; $display("FAIL row0_wr_dir: got cyc=%0d mode=%h data=%h expected cyc=4 mode=2 data=00", wq[0].cyc, wq[0].m, wq[0].d); end
    end
    total++; if (regs[1] !== 8'h20 || regs[2] !== 8'h00)
      begin bad++; $display("FAIL row0_regs: got pos=%h dir=%h expected pos=20 dir=00", regs[1], regs[2]); end

    preload(MODE_T1_POS, 8'h75);
    send(R_RIGHT, R_NONE);
    wait_done("blocked_col7", R_NONE);
    total++; if (txn_cycles != 5) begin bad++; $display("FAIL col7_cycles: got %0d expected 5", txn_cycles); end
    total++; if (wq.size() != 1) begin bad++; $display("FAIL col7_nwrites: got %0d expected 1", wq.size()); end
    if (wq.size() == 1) begin
      total++; if (wq[0].m !== 4'h2 || wq[0].d !== 8'h07 || wq[0].a !== 8'h07)
        begin bad++; $display("FAIL col7_wr_dir: got mode=%h data=%h addr=%h expected mode=2 data=07 addr=07", wq[0].m, wq[0].d, wq[0].a); end
    end
    total++; if (regs[1] !== 8'h75) begin bad++; $display("FAIL col7_t1_pos: got %h expected 75", regs[1]); end
  endtask

  task automatic test_collision();
    preload(MODE_T2_POS, 8'h31);
    preload(MODE_T1_POS, 8'h21);
    send(R_NONE, R_LEFT);
    wait_done("collision", R_NONE);
    total++; if (txn_cycles != 5) begin bad++; $display("FAIL coll_cycles: got %0d expected 5", txn_cycles); end
    total++; if (wq.size() != 1) begin bad++; $display("FAIL coll_nwrites: got %0d expected 1", wq.size()); end
    if (wq.size() == 1) begin
      total++; if (wq[0].m !== 4'h5 || wq[0].d !== 8'h03 || wq[0].a !== 8'h03)
        begin bad++; $display("FAIL coll_wr_dir: got mode=%h data=%h addr=%h expected mode=5 data=03 addr=03", wq[0].m, wq[0].d, wq[0].a); end
    end
    total++; if (regs[4] !== 8'h31) begin bad++; $display("FAIL coll_t2_pos: got %h expected 31", regs[4]); end
  endtask

  task automatic test_fire();
    int extra_busy;
    preload(MODE_T2_POS, 8'h66);
    send(R_NONE, R_FIRE);
    wait_done("fire_p2", R_UP);
    total++; if (txn_cycles != 5) begin bad++; $display("FAIL fire_cycles: got %0d expected 5", txn_cycles); end
    total++; if (wq.size() != 1) begin bad++; $display("FAIL fire_nwrites: got %0d expected 1", wq.size()); end
    if (wq.size() == 1) begin
      total++; if (wq[0].cyc != 4 || wq[0].m !== 4'h6 || wq[0].d !== 8'h66 || wq[0].a !== 8'h66)
        begin bad++; $display("FAIL fire_wr_proj: got cyc=%0d mode=%h data=%h addr=%h expected cyc=4 mode=6 data=66 addr=66", wq[0].cyc, wq[0].m, wq[0].d, wq[0].a); end
      total++; if (wq[0].s2 !== 1'b1 || wq[0].s1 !== 1'b0)
        begin bad++; $display("FAIL fire_shot_cycle: got p1=%b p2=%b expected p1=0 p2=1", wq[0].s1, wq[0].s2); end
    end
    total++; if (shot2_cnt != 1 || shot1_cnt != 0)
      begin bad++; $display("FAIL fire_shot_count: got p1=%0d p2=%0d expected 0 1", shot1_cnt, shot2_cnt); end
    extra_busy = 0;
    repeat (8) begin @(negedge clk); if (busy) extra_busy++; end
    total++; if (extra_busy != 0) begin bad++; $display("FAIL fire_dropped: busy cycles got %0d expected 0", extra_busy); end
    total++; if (regs[6] !== 8'h66 || regs[4] !== 8'h66)
      begin bad++; $display("FAIL fire_regs: got proj=%h pos=%h expected 66 66", regs[6], regs[4]); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    preload(MODE_T1_POS, 8'h21);
    preload(MODE_T2_POS, 8'h66);
    send(R_RIGHT, R_DOWN);
    wait_done("b2b_p1_right", R_NONE);
    total++; if (txn_cycles != 6 || wq.size() != 2) begin bad++; $display("FAIL b2b1_shape: got cycles=%0d writes=%0d expected 6 2", txn_cycles, wq.size()); end
    if (wq.size() == 2) begin
      total++; if (wq[0].m !== 4'h2 || wq[0].d !== 8'h07 || wq[1].m !== 4'h1 || wq[1].d !== 8'h31)
        begin bad++; $display("FAIL b2b1_writes: got %h:%h %h:%h expected 2:07 1:31", wq[0].m, wq[0].d, wq[1].m, wq[1].d); end
    end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle_gap: busy got %b expected 0", busy); end
    wait_done("b2b_p2_down", R_NONE);
    total++; if (txn_cycles != 6 || wq.size() != 2) begin bad++; $display("FAIL b2b2_shape: got cycles=%0d writes=%0d expected 6 2", txn_cycles, wq.size()); end
    if (wq.size() == 2) begin
      total++; if (wq[0].m !== 4'h5 || wq[0].d !== 8'h01 || wq[1].m !== 4'h4 || wq[1].d !== 8'h67)
        begin bad++; $display("FAIL b2b2_writes: got %h:%h %h:%h expected 5:01 4:67", wq[0].m, wq[0].d, wq[1].m, wq[1].d); end
    end
    // Pointer should be back on player 1: a simultaneous fire pair serves p1 first.
    send(R_FIRE, R_FIRE);
    wait_done("b2b_fire_first", R_NONE);
    total++; if (wq.size() != 1) begin bad++; $display("FAIL ptr_first_nwrites: got %0d expected 1", wq.size()); end
    if (wq.size() == 1) begin
      total++; if (wq[0].m !== 4'h3 || wq[0].d !== 8'h31 || wq[0].s1 !== 1'b1)
        begin bad++; $display("FAIL ptr_first: got mode=%h data=%h p1_shot=%b expected 3 31 1", wq[0].m, wq[0].d, wq[0].s1); end
    end
    wait_done("b2b_fire_second", R_NONE);
    total++; if (wq.size() != 1) begin bad++; $display("FAIL ptr_second_nwrites: got %0d expected 1", wq.size()); end
    if (wq.size() == 1) begin
      total++; if (wq[0].m !== 4'h6 || wq[0].d !== 8'h67 || wq[0].s2 !== 1'b1)
        begin bad++; $display("FAIL ptr_second: got mode=%h data=%h p2_shot=%b expected 6 67 1", wq[0].m, wq[0].d, wq[0].s2); end
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    int late_busy;
    preload(MODE_T1_POS, 8'h21);
    preload(MODE_T1_DIR, 8'h55);
    preload(MODE_T2_POS, 8'h66);
    send(R_UP, R_NONE);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (wren && mode == MODE_T1_DIR) begin reset = 1'b0; seen = 1; end
    end
    total++; if (!seen) begin bad++; $display("FAIL mid_wr_dir_seen: WR_DIR not reached within 20 cycles"); end
    @(negedge clk);
    $display("txn reset_mid: reset applied in WR_DIR");
    total++; if (mode !== 4'h0 || wren !== 1'b0 || address !== 8'h00 || data !== 8'h00)
      begin bad++; $display("FAIL mid_outputs: got mode=%h wren=%b addr=%h data=%h expected 0 0 00 00", mode, wren, address, data); end
    total++; if (busy !== 1'b0 || done !== 1'b0 || p1_shot !== 1'b0 || p2_shot !== 1'b0)
      begin bad++; $display("FAIL mid_status: got busy=%b done=%b shots=%b%b expected all 0", busy, done, p1_shot, p2_shot); end
    reset = 1'b1;
    late_busy = 0;
    repeat (8) begin @(negedge clk); if (busy) late_busy++; end
    total++; if (late_busy != 0) begin bad++; $display("FAIL mid_slot_cleared: busy cycles got %0d expected 0", late_busy); end
    total++; if (regs[1] !== 8'h21 || regs[2] !== 8'h00)
      begin bad++; $display("FAIL mid_regs: got pos=%h dir=%h expected pos=21 dir=00", regs[1], regs[2]); end
  endtask

  initial begin
    test_reset();
    test_legal_move();
    test_blocked_edge();
    test_collision();
    test_fire();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tank_command_sequencer.md
# tank_command_sequencer

Turns per-player button requests (move, fire) into read-modify-write transactions on the `storage` block's register port. Sits directly upstream of `storage`: it owns `mode`, `wren`, `address` and `data`, and reads back `q`. It arbitrates between the two players, bounds-checks moves against the grid and blocks moves into the other tank. Every accepted request produces exactly one complete transaction.

## Interface
- `GRID_COLS`, default 8: columns; column index is `address[7:4]`.
- `GRID_ROWS`, default 8: rows; row index is `address[3:0]`.
- `clk` in 1: single clock. All logic is rising-edge.
- `reset` in 1: synchronous, active-low. It is sampled on the `clk` edge, and a low level clears all state.
- `p1_up`, `p1_down`, `p1_left`, `p1_right`, `p1_fire` in 1 each: player-1 request pulses, one cycle wide.
- `p2_up`, `p2_down`, `p2_left`, `p2_right`, `p2_fire` in 1 each: player-2 request pulses.
- `q` in 8: read data from `storage`. It is valid the cycle after `mode` is presented.
- `mode` out 4: `storage` register select.
  - 0001 tank1 position, 0010 tank1 direction, 0011 tank1 projectile.
  - 0100 tank2 position, 0101 tank2 direction, 0110 tank2 projectile.
- `wren` out 1: `storage` write strobe.
- `address` out 8: write value, mirrored from `data` on every register write.
- `data` out 8: write value.
- `busy` out 1: high while a transaction is in flight.
- `done` out 1: one-cycle pulse when a transaction finishes.
- `p1_shot`, `p2_shot` out 1: one-cycle pulse when that player's projectile is launched.

## Operation
- **Request latching:** each player has one pending slot (command plus valid bit).
  - A pulse is latched only when that player's slot is empty.
  - Pulses arriving while the slot is full are dropped.
  - Same-cycle pulses from one player resolve by priority: fire > up > down > left > right.
- **Arbitration:** round-robin pointer, reset to player 1.
  - In IDLE, the pointed player is served if pending; otherwise the other player is served.
  - The pointer toggles after each served transaction.
- **FSM states:** IDLE, RD_SELF, RD_OTHER, CHECK, WR_DIR, WR_POS, WR_PROJ, DONE.
  - IDLE → RD_SELF when any slot is pending.
  - RD_SELF drives `mode` = self position.
  - RD_OTHER drives `mode` = other position and captures `q` as self_pos.
  - CHECK captures `q` as other_pos and computes target.
  - Move command: CHECK → WR_DIR → WR_POS (if legal) → DONE. If the move is illegal, WR_DIR → DONE.
  - Fire command: CHECK → WR_PROJ → DONE.
  - DONE pulses `done`, clears the served slot and returns to IDLE.
- **Direction codes** written in WR_DIR: up 00000000, down 00000001, left 00000011, right 00000111. The direction is written even when the move is blocked.
- **Move arithmetic** is 4-bit unsigned per field; the other field is unchanged.
  - up: row−1, legal if row>0.
  - down: row+1, legal if row<GRID_ROWS−1.
  - left: col−1, legal if col>0.
  - right: col+1, legal if col<GRID_COLS−1.
- **Collision:** a move is also illegal if target == other_pos.
- **Fire:** WR_PROJ writes self_pos to that player's projectile register and pulses `pN_shot` in the same cycle.
- **Defaults outside write states:** `wren`=0. `mode` holds 0000 in IDLE and DONE; `address`/`data` hold their last value.
- **Reset values:** `mode`=0000, `wren`=0, `address`=0, `data`=0, `busy`=0, `done`=0, `p1_shot`=`p2_shot`=0. Both slots empty, state IDLE, pointer = player 1.
- **Reset mid-transaction** aborts immediately: no further writes, and the pending request is discarded.

## Timing
- Request pulse latched at edge N; IDLE leaves at edge N+1 at the earliest.
- Legal move: RD_SELF, RD_OTHER, CHECK, WR_DIR, WR_POS, DONE = 6 cycles. `wren` is high in cycles 4 and 5.
- Blocked move: 5 cycles, with one write.
- Fire: 5 cycles, with one write in cycle 4.
- `busy` is high from RD_SELF through DONE inclusive.
- A request latched during DONE is served from IDLE on the next cycle.
- No back-to-back transactions without passing through IDLE.

## Structure
- `game_pkg` holds:
  - mode codes (MODE_T1_POS … MODE_T2_PROJ);
  - direction codes (DIR_UP/DOWN/LEFT/RIGHT);
  - command encoding (CMD_FIRE, CMD_UP, CMD_DOWN, CMD_LEFT, CMD_RIGHT);
  - FSM state enum.
- One combinational sub-module, `grid_step`: inputs self_pos, other_pos and command; outputs target and legal. Parameterised by GRID_COLS/GRID_ROWS.

## Test plan
- `p1_up`, storage tank1=0x21, tank2=0x66 → WR_DIR `mode`=0010 `data`=0x00. Then WR_POS `mode`=0001 `data`=`address`=0x20. `done` 6 cycles after IDLE exit.
- `p1_up`, tank1=0x20 (row 0) → single write, 0x00 to `mode` 0010. No position write; 5-cycle transaction.
- `p2_left`, tank2=0x31, tank1=0x21 → collision. Writes 0x03 to `mode` 0101 only.
- `p1_right` and `p2_down` in the same cycle → player-1 transaction completes first, then player 2 (0x66→0x67). Pointer ends on player 1.
- `p2_fire`, tank2=0x66 → `mode`=0110 `data`=0x66 `wren`=1 with a `p2_shot` pulse in the same cycle. Extra `p2_up` pulses during the transaction are dropped.
- Reset low during WR_DIR of a move → no WR_POS write. All outputs return to reset values the next cycle; slots empty.
